// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial add scheduler.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to hold a count of 0..w (used to size the bit counter).
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_full_adder_bit.sv
// One-bit full adder with a registered carry, for LSB-first serial addition.
// The sum and the next carry are combinational from the current operand bits
// and the stored carry; the carry advances only on enabled cycles.
module serial_full_adder_bit (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);

  logic carry;

  assign sum  = a ^ b ^ carry;
  assign cout = (a & b) | (carry & (a ^ b));

  // Carry register: sync clear wins over enable so a new operation starts from 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry <= 1'b0;
    end else if (clr) begin
      carry <= 1'b0;
    end else if (en) begin
      carry <= cout;
    end
  end

endmodule

// File: rtl/serial_add_scheduler.sv
// Round-robin scheduler sharing one serial full adder between two requesters.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for a request; grant is combinational, ready = grant
//   RUN   | one operand bit pair per cycle through the adder, LSB first
//   DONE  | result presented on res_*; held until res_ready
//
// The result register fills from the MSB side, so after W shifts bit 0 of
// the sum has landed in res_sum[0].
module serial_add_scheduler
  import serial_add_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_sum,
  output logic         res_carry,
  output logic         res_id
);

  localparam int CW = cnt_w(W);

  state_t         state;
  state_t         state_nxt;
  logic           last_grant;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   sh_a;
  logic [W-1:0]   sh_b;
  logic           grant0;
  logic           grant1;
  logic           accept;
  logic           last_bit;
  logic           adder_en;
  logic           sum_bit;
  logic           carry_out;

  // Arbitration: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant);
    grant1 = req1_valid & (~req0_valid | ~last_grant);
  end

  // Readys are gated by rst so nothing can look accepted while held in reset.
  assign req0_ready = rst & (state == IDLE) & grant0;
  assign req1_ready = rst & (state == IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;

  assign adder_en  = (state == RUN);
  assign last_bit  = adder_en && (cnt == CW'(W - 1));
  assign res_valid = (state == DONE);

  serial_full_adder_bit u_adder (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (adder_en),
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .sum  (sum_bit),
    .cout (carry_out)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept -> W serial cycles -> hold until consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)    state_nxt = RUN;
      RUN:  if (last_bit)  state_nxt = DONE;
      DONE: if (res_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Datapath: operand load on accept, serial shift and result collection in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= 1'b1;
      cnt        <= '0;
      sh_a       <= '0;
      sh_b       <= '0;
      res_sum    <= '0;
      res_carry  <= 1'b0;
      res_id     <= 1'b0;
    end else if (accept) begin
      sh_a       <= req1_ready ? req1_a : req0_a;
      sh_b       <= req1_ready ? req1_b : req0_b;
      res_id     <= req1_ready;
      last_grant <= req1_ready;
      cnt        <= '0;
    end else if (adder_en) begin
      sh_a    <= sh_a >> 1;
      sh_b    <= sh_b >> 1;
      res_sum <= (res_sum >> 1) | (W'(sum_bit) << (W - 1));
      cnt     <= cnt + CW'(1);
      if (last_bit) begin
        res_carry <= carry_out;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Self-checking bench: directed cases plus randomized requests against a
// reference model that works on whole operands (plain addition, round-robin flag).
module tb_serial_add_scheduler;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_carry;
  logic         res_id;

  int n_checks = 0;
  int n_errors = 0;
  bit model_last = 1'b1;

  serial_add_scheduler #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_sum    (res_sum),
    .res_carry  (res_carry),
    .res_id     (res_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One complete transaction, called at posedge+1 with the DUT in IDLE.
  task automatic run_op(input bit v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input bit v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                        input int hold);
    bit         g;
    logic [W:0] full;
    int         lat;
    g = (v0 && v1) ? ~model_last : v1;
    full = g ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
    res_ready  = 1'b0;
    #1;
    chk("grant0", req0_ready, (g == 1'b0));
    chk("grant1", req1_ready, (g == 1'b1));
    @(posedge clk); #1;
    model_last = g;
    lat = 0;
    while (!res_valid && lat < 4 * W + 8) begin
      req0_valid = 1'($urandom); req0_a = W'($urandom); req0_b = W'($urandom);
      req1_valid = 1'($urandom); req1_a = W'($urandom); req1_b = W'($urandom);
      #1;
      chk("ready_busy", {req0_ready, req1_ready}, 2'b00);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, W);
    chk("sum", res_sum, full[W-1:0]);
    chk("carry", res_carry, full[W]);
    chk("id", res_id, g);
    for (int i = 0; i < hold; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = W'($urandom); req1_a = W'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", res_valid, 1'b1);
      chk("hold_sum", res_sum, full[W-1:0]);
      chk("hold_carry", res_carry, full[W]);
      chk("hold_ready", {req0_ready, req1_ready}, 2'b00);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("valid_drop", res_valid, 1'b0);
    chk("sum_kept", res_sum, full[W-1:0]);
    chk("id_kept", res_id, g);
  endtask

  initial begin
    bit v0;
    bit v1;
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 8'd9; req0_b = 8'd9;
    req1_valid = 1'b1; req1_a = 8'd7; req1_b = 8'd7;
    res_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {req0_ready, req1_ready}, 2'b00);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_out", {res_sum, res_carry, res_id}, '0);
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    @(posedge clk); #1;

    run_op(1, 8'd5, 8'd3, 0, 8'd0, 8'd0, 0);
    run_op(0, 8'd0, 8'd0, 1, 8'd200, 8'd100, 0);

    // Contention: fresh round-robin state after a reset.
    rst = 1'b0; #1; rst = 1'b1; model_last = 1'b1;
    @(posedge clk); #1;
    run_op(1, 8'd1, 8'd1, 1, 8'd2, 8'd2, 0);
    run_op(1, 8'd1, 8'd1, 1, 8'd2, 8'd2, 0);
    run_op(1, 8'd3, 8'd3, 1, 8'd2, 8'd2, 0);
    run_op(1, 8'd77, 8'd99, 0, 8'd0, 8'd0, 5);

    // Back-to-back: a carry left over from 255+1 must not leak into 0+0.
    run_op(1, 8'd255, 8'd1, 0, 8'd0, 8'd0, 0);
    run_op(1, 8'd0, 8'd0, 0, 8'd0, 8'd0, 0);

    // Abort in the middle of RUN.
    req0_valid = 1'b1; req0_a = 8'd255; req0_b = 8'd1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort_out", {res_valid, res_sum, res_carry, res_id}, '0);
    req0_valid = 1'b1;
    #1;
    chk("abort_ready", req0_ready, 1'b0);
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_last = 1'b1;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      chk("abort_novalid", res_valid, 1'b0);
    end
    run_op(1, 8'd0, 8'd0, 0, 8'd0, 8'd0, 0);
    run_op(1, 8'd128, 8'd128, 1, 8'd15, 8'd1, 1);

    for (int n = 0; n < 40; n++) begin
      v0 = 1'($urandom);
      v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      run_op(v0, W'($urandom), W'($urandom), v1, W'($urandom), W'($urandom),
             int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
